ssram_arbiter_2to1: RTL and testbench
=====================================

# ssram_arbiter_2to1

Two-requester arbiter that shares one single-port synchronous SRAM between two SRAM-style masters, for example an instruction-side and a data-side AHB-to-SSRAM bridge. It grants at most one access per cycle under round-robin priority. It steers write strobes and address to the SRAM. Read data is routed back to its owner one cycle later, and each port's last read word is held stable until that port's next accepted read.

## Interface
Parameters:
- AW, 12, SRAM word-address/byte-address width passed through unchanged

Ports (p = 0, 1; each port has identical m{p}_* signals):
- HCLK  in  1  clock; all state on rising edge
- HRESETn  in  1  reset, asynchronous, active-low
- m{p}_req  in  1  access request; held until granted
- m{p}_we  in  1  1 = write, 0 = read
- m{p}_wb  in  4  byte write strobes; ignored for reads
- m{p}_addr  in  AW  access address
- m{p}_wdata  in  32  write data, same cycle as req
- m{p}_gnt  out  1  access accepted this cycle (req & gnt)
- m{p}_rvalid  out  1  read data valid; one cycle after an accepted read
- m{p}_rdata  out  32  read data for port p
- sram_en  out  1  SRAM access enable
- sram_we  out  1  SRAM write enable
- sram_wb  out  4  SRAM byte write strobes
- sram_addr  out  AW  SRAM address
- sram_din  out  32  SRAM write data
- sram_dout  in  32  SRAM read data; valid the cycle after a read enable

## Operation
- Arbitration is combinational from req and the register last_gnt:
  - Only one port requesting: that port is granted.
  - Both ports requesting: the port != last_gnt is granted.
  - No port requesting: no grant, sram_en = 0.
- Exactly one gnt may be high in any cycle; gnt is never high without its req.
- last_gnt is updated to the granted port on every grant edge and holds otherwise. Reset value is 1, so m0 wins the first conflict.
- SRAM drive while port g is granted:
  - sram_en = 1
  - sram_we = m{g}_we
  - sram_addr = m{g}_addr
  - sram_din = m{g}_wdata
  - sram_wb = m{g}_we ? m{g}_wb : 4'b0000
- SRAM drive with no grant: sram_en = 0, sram_we = 0, sram_wb = 0. sram_addr and sram_din follow m0 (don't-care).
- Read return: the register rd_pend[p] is set for exactly one cycle after port p has an accepted read. Writes never set rd_pend.
- m{p}_rvalid = rd_pend[p].
- m{p}_rdata = rd_pend[p] ? sram_dout : hold_p. hold_p loads sram_dout whenever rd_pend[p] = 1.
- Result: rdata stays stable after rvalid drops, including while the other port uses the SRAM.
- Writes complete on their grant cycle and have no response.

## Timing
- Grant latency: 0 cycles. A request with no contention is accepted the same cycle.
- Read latency: rvalid and data appear 1 cycle after the grant cycle.
- Throughput: one access per cycle in total. Under continuous contention, grants alternate m0, m1, m0, …
- A loser waits at most 1 cycle while its req stays high.
- Back-to-back reads from the same port are allowed. rvalid stays high on consecutive cycles with the new data each cycle.
- Read-after-write to the same address on consecutive cycles returns the newly written data; this relies on the SRAM's write-then-read ordering, and the arbiter adds no bypass.
- No combinational path from sram_dout to any gnt or sram_* control output.
- Simultaneous events:
  - Read accepted for port p in cycle n while rd_pend[q] is set from cycle n-1: both are legal.
  - rd_pend[q] returns data in cycle n, and the new read returns in cycle n+1.
- Reset (asynchronous assert, any time including mid-read):
  - last_gnt = 1; rd_pend = 00; hold_0 = hold_1 = 0.
  - Outputs: rvalid = 0, rdata = 0, sram_en = 0, sram_we = 0, sram_wb = 0.
  - gnt = 0 while req = 0.
  - A pending read is dropped with no rvalid after deassertion.
- Reset deassertion: the first edge after release may grant.

## Test plan
- Reset: assert HRESETn low mid-read with both req high -> rvalid 00, rdata 0, sram_en 0. After release with only m1_req high, m1_gnt = 1 on the same cycle.
- Single port: m0 writes 0xDEADBEEF to addr 0x010 with wb 1111, then reads 0x010 -> gnt each cycle, sram_wb 1111 then 0000, m0_rvalid one cycle after the read, m0_rdata = 0xDEADBEEF.
- Contention: both ports read (m0 addr 0x004, m1 addr 0x008) with req held for 4 cycles after reset -> grants m0, m1, m0, m1. Each rvalid follows its grant by 1 cycle with the correct data.
- Hold: m1 reads 0x020 = 0x12345678, then m0 issues 3 reads of other data -> m1_rdata stays 0x12345678 with m1_rvalid 0 throughout.
- Byte strobes: m1 writes 0xAABBCCDD with wb 0100 over word 0x00000000, then m0 reads it -> sram_wb = 0100 on the write and m0_rdata = 0x00BB0000.
- Interleave: m0 write and m1 read in conflict, last_gnt = 0 -> m1 granted first, m0 next cycle. m1_rvalid appears in the same cycle as m0's write grant, and sram_we = 1 in that cycle only.

Source files
------------

// File: rtl/ssram_arbiter_2to1_if.sv
`default_nettype none
// ============================================================================
// Module   : ssram_arbiter_2to1_if
// Purpose  : Bundles both requester ports and the shared SSRAM port.
// Revision : 1.0 - initial release
// ============================================================================
interface ssram_arbiter_2to1_if #(
   parameter int AW = 12
);
   logic          m0_req;
   logic          m0_we;
   logic [3:0]    m0_wb;
   logic [AW-1:0] m0_addr;
   logic [31:0]   m0_wdata;
   logic          m0_gnt;
   logic          m0_rvalid;
   logic [31:0]   m0_rdata;

   logic          m1_req;
   logic          m1_we;
   logic [3:0]    m1_wb;
   logic [AW-1:0] m1_addr;
   logic [31:0]   m1_wdata;
   logic          m1_gnt;
   logic          m1_rvalid;
   logic [31:0]   m1_rdata;

   logic          sram_en;
   logic          sram_we;
   logic [3:0]    sram_wb;
   logic [AW-1:0] sram_addr;
   logic [31:0]   sram_din;
   logic [31:0]   sram_dout;

   // Requesters plus the SRAM model sit on the master side.
   modport master (
      output m0_req, m0_we, m0_wb, m0_addr, m0_wdata,
      input  m0_gnt, m0_rvalid, m0_rdata,
      output m1_req, m1_we, m1_wb, m1_addr, m1_wdata,
      input  m1_gnt, m1_rvalid, m1_rdata,
      input  sram_en, sram_we, sram_wb, sram_addr, sram_din,
      output sram_dout
   );

   modport slave (
      input  m0_req, m0_we, m0_wb, m0_addr, m0_wdata,
      output m0_gnt, m0_rvalid, m0_rdata,
      input  m1_req, m1_we, m1_wb, m1_addr, m1_wdata,
      output m1_gnt, m1_rvalid, m1_rdata,
      output sram_en, sram_we, sram_wb, sram_addr, sram_din,
      input  sram_dout
   );
endinterface
`default_nettype wire

// File: rtl/ssram_arbiter_2to1.sv
`default_nettype none
// ============================================================================
// Module   : ssram_arbiter_2to1
// Purpose  : Round-robin 2:1 arbiter sharing one single-port SSRAM.
// Revision : 1.0 - initial release
// ============================================================================
module ssram_arbiter_2to1 #(
   parameter int AW = 12
) (
   input  logic                 HCLK,
   input  logic                 HRESETn,
   ssram_arbiter_2to1_if.slave  bus
);

   logic          r_last_gnt;
   logic [1:0]    r_rd_pend;
   logic [31:0]   r_hold0;
   logic [31:0]   r_hold1;

   logic          w_gnt0;
   logic          w_gnt1;
   logic          w_we;
   logic [3:0]    w_wb;
   logic [AW-1:0] w_addr;
   logic [31:0]   w_din;

   // Grants are masked while reset is held so the SRAM stays idle even with req high.
   always_comb begin
      w_gnt0 = HRESETn & bus.m0_req & (~bus.m1_req | r_last_gnt);
      w_gnt1 = HRESETn & bus.m1_req & (~bus.m0_req | ~r_last_gnt);
      w_we   = (w_gnt0 & bus.m0_we) | (w_gnt1 & bus.m1_we);
      w_wb   = 4'b0000;
      if (w_gnt0 && bus.m0_we) begin
         w_wb = bus.m0_wb;
      end else if (w_gnt1 && bus.m1_we) begin
         w_wb = bus.m1_wb;
      end
      w_addr = w_gnt1 ? bus.m1_addr  : bus.m0_addr;
      w_din  = w_gnt1 ? bus.m1_wdata : bus.m0_wdata;
   end

   assign bus.m0_gnt    = w_gnt0;
   assign bus.m1_gnt    = w_gnt1;
   assign bus.sram_en   = w_gnt0 | w_gnt1;
   assign bus.sram_we   = w_we;
   assign bus.sram_wb   = w_wb;
   assign bus.sram_addr = w_addr;
   assign bus.sram_din  = w_din;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_last_gnt <= 1'b1;
         r_rd_pend  <= 2'b00;
         r_hold0    <= 32'h0;
         r_hold1    <= 32'h0;
      end else begin
         if (w_gnt0 || w_gnt1) begin
            r_last_gnt <= w_gnt1;
         end
         r_rd_pend <= {w_gnt1 & ~bus.m1_we, w_gnt0 & ~bus.m0_we};
         if (r_rd_pend[0]) begin
            r_hold0 <= bus.sram_dout;
         end
         if (r_rd_pend[1]) begin
            r_hold1 <= bus.sram_dout;
         end
      end
   end

   // Each port keeps its last word so the other port's traffic cannot disturb it.
   assign bus.m0_rvalid = r_rd_pend[0];
   assign bus.m1_rvalid = r_rd_pend[1];
   assign bus.m0_rdata  = r_rd_pend[0] ? bus.sram_dout : r_hold0;
   assign bus.m1_rdata  = r_rd_pend[1] ? bus.sram_dout : r_hold1;

endmodule
`default_nettype wire

// File: tb/tb_ssram_arbiter_2to1.sv
`default_nettype none
// ============================================================================
// Module   : tb_ssram_arbiter_2to1
// Purpose  : Scoreboard bench: reference memory model plus read-return monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ssram_arbiter_2to1;

   localparam int AW = 12;

   logic clk;
   logic rst_n;
   int   cyc;
   int   checks;
   int   errors;

   ssram_arbiter_2to1_if #(.AW(AW)) bus ();

   ssram_arbiter_2to1 #(.AW(AW)) dut (
      .HCLK    (clk),
      .HRESETn (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // SRAM behavioural model: write-then-read, data one cycle after enable.
   logic [31:0] sram_mem [0:4095];
   always @(posedge clk) begin
      if (bus.sram_en) begin
         if (bus.sram_we) begin
            for (int b = 0; b < 4; b++)
               if (bus.sram_wb[b]) sram_mem[bus.sram_addr][8*b +: 8] <= bus.sram_din[8*b +: 8];
         end else begin
            bus.sram_dout <= sram_mem[bus.sram_addr];
         end
      end
   end

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endfunction

   // ---------------- reference model ----------------
   typedef struct { int due; logic [31:0] data; } rd_t;
   rd_t         q0[$];
   rd_t         q1[$];
   logic [31:0] ref_mem [0:4095];
   int          m_last;

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_gnt", {30'd0, bus.m1_gnt, bus.m0_gnt}, 32'd0);
         chk("rst_en",  {29'd0, bus.sram_en, bus.sram_we, |bus.sram_wb}, 32'd0);
         chk("rst_rvalid", {30'd0, bus.m1_rvalid, bus.m0_rvalid}, 32'd0);
         chk("rst_rdata0", bus.m0_rdata, 32'd0);
         chk("rst_rdata1", bus.m1_rdata, 32'd0);
         m_last = 1;
         q0.delete();
         q1.delete();
      end else begin
         int          win;
         logic        we;
         logic [3:0]  wb;
         logic [11:0] a;
         logic [31:0] d;
         win = -1;
         if (bus.m0_req && bus.m1_req) win = (m_last == 0) ? 1 : 0;
         else if (bus.m0_req)          win = 0;
         else if (bus.m1_req)          win = 1;
         chk("gnt", {30'd0, bus.m1_gnt, bus.m0_gnt},
             (win < 0) ? 32'd0 : (32'd1 << win));
         chk("sram_en", {31'd0, bus.sram_en}, {31'd0, win >= 0});
         if (win < 0) begin
            chk("idle_we_wb", {27'd0, bus.sram_we, bus.sram_wb}, 32'd0);
         end else begin
            we = (win == 0) ? bus.m0_we    : bus.m1_we;
            wb = (win == 0) ? bus.m0_wb    : bus.m1_wb;
            a  = (win == 0) ? bus.m0_addr  : bus.m1_addr;
            d  = (win == 0) ? bus.m0_wdata : bus.m1_wdata;
            chk("sram_we",   {31'd0, bus.sram_we}, {31'd0, we});
            chk("sram_wb",   {28'd0, bus.sram_wb}, we ? {28'd0, wb} : 32'd0);
            chk("sram_addr", {20'd0, bus.sram_addr}, {20'd0, a});
            if (we) begin
               chk("sram_din", bus.sram_din, d);
               for (int b = 0; b < 4; b++)
                  if (wb[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
            end else if (win == 0) begin
               q0.push_back('{cyc + 1, ref_mem[a]});
            end else begin
               q1.push_back('{cyc + 1, ref_mem[a]});
            end
            m_last = win;
         end
      end
   end

   // ---------------- read-return monitor ----------------
   logic [31:0] last0, last1;
   always @(negedge clk) begin
      #2;
      if (!rst_n) begin
         last0 = 32'd0;
         last1 = 32'd0;
      end else begin
         if (bus.m0_rvalid) begin
            if (q0.size() == 0) chk("m0_spurious_rvalid", 32'd1, 32'd0);
            else begin
               rd_t e;
               e = q0.pop_front();
               chk("m0_rvalid_lat", cyc, e.due);
               chk("m0_rdata", bus.m0_rdata, e.data);
               last0 = e.data;
            end
         end else begin
            chk("m0_hold", bus.m0_rdata, last0);
            if (q0.size() != 0 && q0[0].due <= cyc) begin
               chk("m0_missing_rvalid", 32'd0, 32'd1);
               void'(q0.pop_front());
            end
         end
         if (bus.m1_rvalid) begin
            if (q1.size() == 0) chk("m1_spurious_rvalid", 32'd1, 32'd0);
            else begin
               rd_t e;
               e = q1.pop_front();
               chk("m1_rvalid_lat", cyc, e.due);
               chk("m1_rdata", bus.m1_rdata, e.data);
               last1 = e.data;
            end
         end else begin
            chk("m1_hold", bus.m1_rdata, last1);
            if (q1.size() != 0 && q1[0].due <= cyc) begin
               chk("m1_missing_rvalid", 32'd0, 32'd1);
               void'(q1.pop_front());
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic setp(int p, bit r, bit we, logic [3:0] wb, logic [11:0] a, logic [31:0] d);
      if (p == 0) begin
         bus.m0_req = r; bus.m0_we = we; bus.m0_wb = wb; bus.m0_addr = a; bus.m0_wdata = d;
      end else begin
         bus.m1_req = r; bus.m1_we = we; bus.m1_wb = wb; bus.m1_addr = a; bus.m1_wdata = d;
      end
   endtask

   task automatic step(int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idle();
      setp(0, 0, 0, 4'h0, 12'h0, 32'h0);
      setp(1, 0, 0, 4'h0, 12'h0, 32'h0);
   endtask

   initial begin
      bit g0, g1;
      cyc = 0; checks = 0; errors = 0;
      for (int i = 0; i < 4096; i++) begin
         sram_mem[i] = 32'd0;
         ref_mem[i]  = 32'd0;
      end
      sram_mem[12'h020] = 32'h12345678; ref_mem[12'h020] = 32'h12345678;
      sram_mem[12'h004] = 32'h0000_4444; ref_mem[12'h004] = 32'h0000_4444;
      sram_mem[12'h008] = 32'h0000_8888; ref_mem[12'h008] = 32'h0000_8888;
      bus.sram_dout = 32'd0;
      rst_n = 1'b0;
      idle();
      step(3);
      rst_n = 1'b1;

      // hold: m1 read, then m0 write/read and three more reads
      setp(1, 1, 0, 4'h0, 12'h020, 32'h0);             step();
      idle();
      setp(0, 1, 1, 4'hF, 12'h010, 32'hDEADBEEF);      step();
      setp(0, 1, 0, 4'h0, 12'h010, 32'h0);             step();
      setp(0, 1, 0, 4'h0, 12'h004, 32'h0);             step();
      setp(0, 1, 0, 4'h0, 12'h008, 32'h0);             step();
      setp(0, 1, 0, 4'h0, 12'h004, 32'h0);             step();
      idle();                                          step();
      chk("dir_m1_hold", bus.m1_rdata, 32'h12345678);

      // byte strobes
      setp(1, 1, 1, 4'b0100, 12'h000, 32'hAABBCCDD);   step();
      idle();
      setp(0, 1, 0, 4'h0, 12'h000, 32'h0);             step();
      idle();                                          step();
      chk("dir_byte_strobe", bus.m0_rdata, 32'h00BB0000);

      // contention
      setp(0, 1, 0, 4'h0, 12'h004, 32'h0);
      setp(1, 1, 0, 4'h0, 12'h008, 32'h0);             step(4);
      idle();                                          step();

      // interleave with last_gnt = 0
      setp(0, 1, 0, 4'h0, 12'h004, 32'h0);             step();
      setp(0, 1, 1, 4'hF, 12'h030, 32'hCAFEF00D);
      setp(1, 1, 0, 4'h0, 12'h020, 32'h0);             step();
      setp(1, 0, 0, 4'h0, 12'h0, 32'h0);               step();
      idle();                                          step();

      // random traffic, requests held until granted
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         g0 = bus.m0_gnt; g1 = bus.m1_gnt;
         step();
         if (!(bus.m0_req && !g0))
            setp(0, ($urandom % 4) != 0, $urandom % 2, 4'($urandom), 12'($urandom % 16), $urandom);
         if (!(bus.m1_req && !g1))
            setp(1, ($urandom % 4) != 0, $urandom % 2, 4'($urandom), 12'($urandom % 16), $urandom);
      end

      // reset mid-read with both req high
      setp(0, 1, 0, 4'h0, 12'h004, 32'h0);
      setp(1, 1, 0, 4'h0, 12'h008, 32'h0);
      step();
      @(posedge clk); #3;
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      setp(0, 0, 0, 4'h0, 12'h0, 32'h0);
      setp(1, 1, 0, 4'h0, 12'h020, 32'h0);
      @(negedge clk);
      chk("post_rst_m1_gnt", {31'd0, bus.m1_gnt}, 32'd1);
      step();
      idle();
      step(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
